// File: rtl/fwd_layer_accum_if.sv
// Bundle between fwd_layer_accum and its host: run control, weight row,
// activation RAM port and result sums.
`timescale 1ns/1ps
interface fwd_layer_accum_if #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 128,
    parameter int W     = 32
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                    start;
    logic                    w_start;
    logic [N_OUT-1:0][W-1:0] w_values;
    logic [AW-1:0]           x_addr;
    logic [W-1:0]            x_data;
    logic                    busy;
    logic                    done;
    logic [N_OUT-1:0][W-1:0] sums;

    modport master (
        output start, w_values, x_data,
        input  w_start, x_addr, busy, done, sums
    );

    modport slave (
        input  start, w_values, x_data,
        output w_start, x_addr, busy, done, sums
    );
endinterface

// File: rtl/fwd_layer_accum.sv
// Forward-layer MAC: streams N_IN activations against weight rows into N_OUT
// saturating Q-format sums. Define FWD_RELU_EN to clamp negative sums to zero.
`timescale 1ns/1ps
module fwd_layer_accum #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 128,
    parameter int W     = 32,
    parameter int FRAC  = 16
) (
    input logic              clka,
    input logic              rst_n,
    fwd_layer_accum_if.slave bus
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

    state_t                  state;
    logic [AW-1:0]           cnt;
    logic [N_OUT-1:0][W-1:0] acc;
    logic [N_OUT-1:0][W-1:0] acc_nxt;
    logic [N_OUT-1:0][W-1:0] res;

    for (genvar j = 0; j < N_OUT; j++) begin : g_mac
        logic signed [2*W-1:0] prod;
        logic signed [2*W-1:0] t;
        logic signed [W:0]     tc;
        logic signed [W+1:0]   s;
        logic [W-1:0]          nxt;

        assign prod = $signed(bus.x_data) * $signed(bus.w_values[j]);
        assign t    = prod >>> FRAC;

        // Pre-clamp the term to W+1 bits so the W+2 bit sum cannot wrap
        always_comb begin
            if (!t[2*W-1] && (|t[2*W-2:W]))
                tc = {1'b0, {W{1'b1}}};
            else if (t[2*W-1] && !(&t[2*W-2:W]))
                tc = {1'b1, {W{1'b0}}};
            else
                tc = t[W:0];
        end

        assign s = {tc[W], tc} + {{2{acc[j][W-1]}}, acc[j]};

        always_comb begin
            if (!s[W+1] && (s[W] | s[W-1]))
                nxt = {1'b0, {(W-1){1'b1}}};
            else if (s[W+1] && !(s[W] & s[W-1]))
                nxt = {1'b1, {(W-1){1'b0}}};
            else
                nxt = s[W-1:0];
        end

        assign acc_nxt[j] = nxt;

`ifdef FWD_RELU_EN
        assign res[j] = nxt[W-1] ? '0 : nxt;
`else
        assign res[j] = nxt;
`endif
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            bus.w_start <= 1'b0;
            bus.x_addr  <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.sums    <= '0;
        end else begin
            bus.w_start <= 1'b0;
            bus.done    <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state       <= REQ;
                        bus.w_start <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.x_addr  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    state      <= RUN;
                    acc        <= '0;
                    cnt        <= '0;
                    bus.x_addr <= (N_IN > 1) ? AW'(1) : '0;
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        bus.sums <= res;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Address runs one ahead of the row and parks on the last entry
                        if (cnt >= LAST - 1'b1)
                            bus.x_addr <= LAST;
                        else
                            bus.x_addr <= cnt + AW'(2);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fwd_layer_accum.sv
// Randomised + directed bench for fwd_layer_accum against an arithmetic
// reference model; also models the weight streamer and activation RAM.
`timescale 1ns/1ps
module tb_fwd_layer_accum;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int W     = 32;
    localparam int FRAC  = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    int xmem [N_IN];
    int wmem [N_IN][N_OUT];
    int sidx;
    logic [N_OUT-1:0][W-1:0] prev;

    fwd_layer_accum_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) bus ();

    fwd_layer_accum #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W(W), .FRAC(FRAC)
    ) u_dut (
        .clka  (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.x_data <= xmem[bus.x_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sidx <= N_IN;
            bus.w_values <= '0;
        end else if (bus.w_start) begin
            for (int j = 0; j < N_OUT; j++) bus.w_values[j] <= wmem[0][j];
            sidx <= 1;
        end else if (sidx < N_IN) begin
            for (int j = 0; j < N_OUT; j++) bus.w_values[j] <= wmem[sidx][j];
            sidx <= sidx + 1;
        end else begin
            bus.w_values <= '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(output logic [N_OUT-1:0][W-1:0] r);
        longint a, p;
        for (int j = 0; j < N_OUT; j++) begin
            a = 0;
            for (int k = 0; k < N_IN; k++) begin
                p = longint'(xmem[k]) * longint'(wmem[k][j]);
                a = a + (p >>> FRAC);
                if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
                if (a < -64'sh8000_0000) a = -64'sh8000_0000;
            end
`ifdef FWD_RELU_EN
            if (a < 0) a = 0;
`endif
            r[j] = W'(a);
        end
    endfunction

    task automatic run_check(input string tag, input bit immediate, input bit poke);
        logic [N_OUT-1:0][W-1:0] exp;
        int lat, ws, ea;
        bit hit;
        model(exp);
        if (!immediate) @(negedge clk);
        bus.start = 1'b1;
        lat = 0; ws = 0; hit = 0;
        for (int c = 1; c <= N_IN + 8 && !hit; c++) begin
            @(negedge clk);
            bus.start = poke && (c == 3);
            if (bus.w_start) ws++;
            if (c <= N_IN + 1) begin
                ea = (c == 1) ? 0 : ((c - 1 < N_IN - 1) ? c - 1 : N_IN - 1);
                chk({tag, ".x_addr"}, 64'(bus.x_addr), 64'(ea));
            end
            if (bus.done) begin
                hit = 1; lat = c;
            end else begin
                chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
                chk({tag, ".held"}, 64'(bus.sums), 64'(prev));
            end
        end
        bus.start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(N_IN + 2));
        chk({tag, ".w_start_cnt"}, 64'(ws), 64'd1);
        chk({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
        for (int j = 0; j < N_OUT; j++)
            chk({tag, ".sum"}, 64'(bus.sums[j]), 64'(exp[j]));
        prev = exp;
    endtask

    task automatic load_basic();
        xmem = '{32'h0001_0000, 32'h0002_0000, 0, 0};
        wmem[0] = '{32'h0001_0000, 32'hFFFF_0000};
        wmem[1] = '{32'h0000_8000, 32'h0000_8000};
        wmem[2] = '{0, 0};
        wmem[3] = '{0, 0};
    endtask

    task automatic load_const(input int xv, input int wv);
        for (int k = 0; k < N_IN; k++) begin
            xmem[k] = xv;
            for (int j = 0; j < N_OUT; j++) wmem[k][j] = wv;
        end
    endtask

    task automatic load_random();
        bit big;
        big = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < N_IN; k++) begin
            xmem[k] = big ? int'($urandom) : int'($urandom_range(0, 524288)) - 262144;
            for (int j = 0; j < N_OUT; j++)
                wmem[k][j] = big ? int'($urandom) : int'($urandom_range(0, 524288)) - 262144;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        prev = '0;
        load_basic();
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.w_start", 64'(bus.w_start), 64'd0);
        chk("rst.x_addr", 64'(bus.x_addr), 64'd0);
        chk("rst.sums", 64'(bus.sums), 64'd0);
        rst_n = 1'b1;

        run_check("basic", 1'b0, 1'b0);
        chk("basic.s0", 64'(bus.sums[0]), 64'h0002_0000);
        chk("basic.s1", 64'(bus.sums[1]), 64'h0000_0000);

        load_const(32'h7FFF_0000, 32'h7FFF_0000);
        run_check("sat_pos", 1'b0, 1'b0);
        chk("sat_pos.s0", 64'(bus.sums[0]), 64'h7FFF_FFFF);

        load_const(32'h7FFF_0000, 32'h8001_0000);
        run_check("sat_neg", 1'b0, 1'b0);
`ifndef FWD_RELU_EN
        chk("sat_neg.s1", 64'(bus.sums[1]), 64'h8000_0000);
`endif

        load_basic();
        run_check("poke", 1'b0, 1'b1);

        load_random();
        run_check("b2b_a", 1'b0, 1'b0);
        load_random();
        run_check("b2b_b", 1'b1, 1'b0);

        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", 64'(bus.busy), 64'd0);
        chk("mid_rst.done", 64'(bus.done), 64'd0);
        chk("mid_rst.w_start", 64'(bus.w_start), 64'd0);
        chk("mid_rst.sums", 64'(bus.sums), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        prev = '0;
        load_basic();
        run_check("after_rst", 1'b0, 1'b0);
        chk("after_rst.s0", 64'(bus.sums[0]), 64'h0002_0000);

        load_const(0, 0);
        xmem[0] = 32'h0001_0000;
        wmem[0] = '{32'hFFFF_0000, 32'h0001_0000};
        run_check("relu", 1'b0, 1'b0);
`ifdef FWD_RELU_EN
        chk("relu.s0", 64'(bus.sums[0]), 64'h0000_0000);
`else
        chk("relu.s0", 64'(bus.sums[0]), 64'hFFFF_0000);
`endif
        chk("relu.s1", 64'(bus.sums[1]), 64'h0001_0000);

        for (int i = 0; i < 16; i++) begin
            load_random();
            run_check("rand", ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
